vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 683, visible pixels per line.
REQ-002 Parameter H_FP, 32, horizontal front-porch pixels.
REQ-003 Parameter H_SYNC, 56, horizontal sync pixels.
REQ-004 Parameter H_BP, 125, horizontal back-porch pixels.
REQ-005 Parameter V_ACTIVE, 768, visible lines per frame.
REQ-006 Parameter V_FP, 3, vertical front-porch lines.
REQ-007 Parameter V_SYNC, 6, vertical sync lines.
REQ-008 Parameter V_BP, 18, vertical back-porch lines.
REQ-009 Parameter H_POL, 0, hsync active level (0 = active-low, 1 = active-high).
REQ-010 Parameter V_POL, 0, vsync active level (0 = active-low, 1 = active-high).
REQ-011 Derived: H_TOTAL = sum of H params (896); V_TOTAL = sum of V params (795); XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).
REQ-012 clk  in  1  sole clock; all logic on rising edge.
REQ-013 rst  in  1  synchronous, active-high reset.
REQ-014 pix_en  in  1  pixel-rate enable; position advances one pixel per clk with pix_en=1.
REQ-015 x  out  XW  current horizontal position, 0..H_TOTAL-1.
REQ-016 y  out  YW  current vertical position, 0..V_TOTAL-1.
REQ-017 de  out  1  display enable: x<H_ACTIVE and y<V_ACTIVE.
REQ-018 hsync  out  1  horizontal sync at H_POL level when active.
REQ-019 vsync  out  1  vertical sync at V_POL level when active.
REQ-020 line_start  out  1  one-clk pulse on entering x=0.
REQ-021 frame_start  out  1  one-clk pulse on entering (0,0).

Function
REQ-022 All outputs SHALL be registered and mutually aligned: every output describes the position shown on x/y in the same cycle.
REQ-023 On a clk edge with pix_en=1, x SHALL increment; at x=H_TOTAL-1 it wraps to 0 and y increments; at y=V_TOTAL-1 with x wrapping, y wraps to 0.
REQ-024 With pix_en=0, x, y, de, hsync and vsync SHALL hold; line_start and frame_start SHALL be 0.
REQ-025 Horizontal phase FSM: ACTIVE (x 0..H_ACTIVE-1) -> FRONT -> SYNC (x H_ACTIVE+H_FP .. +H_SYNC-1) -> BACK -> ACTIVE, transitions only on pix_en edges; vertical FSM identical over y, stepping only on horizontal wrap.
REQ-026 hsync SHALL be at active level exactly when horizontal phase is SYNC; vsync exactly when vertical phase is SYNC, for all x of those lines.
REQ-027 line_start SHALL be 1 for exactly the one clk following the pix_en edge that produced x=0; frame_start likewise for (0,0); line_start is also 1 whenever frame_start is 1.
REQ-028 Each timing parameter SHALL be >=1; otherwise the block fails elaboration.
REQ-029 Counter arithmetic SHALL use XW/YW bits with explicit compare-and-wrap; no reliance on natural overflow.

Reset
REQ-030 During rst=1 (pix_en ignored) outputs SHALL be: x=H_TOTAL-1, y=V_TOTAL-1, de=0, hsync=!H_POL, vsync=!V_POL, line_start=0, frame_start=0, both FSMs in BACK.
REQ-031 The first pix_en edge after rst deasserts SHALL produce (0,0) with frame_start=1, line_start=1, de=1.
REQ-032 Reset asserted mid-frame SHALL take effect at the next clk edge regardless of pix_en.

Structure
REQ-033 Package vga_timing_pkg SHALL hold the phase enum (ACTIVE, FRONT, SYNC, BACK) and the default timing constants.
REQ-034 One sub-module vga_phase_counter (count, wrap flag, phase FSM, parameterised by the four segment lengths and an advance input) SHALL be instantiated twice, horizontal and vertical.

Verification (small config: H 8/2/3/3 => 16, V 4/1/2/1 => 8, unless stated)
REQ-035 rst then pix_en=1 constant -> first enabled edge gives x=0,y=0,de=1,frame_start=1; line_start every 16 clks; frame_start every 128 clks.
REQ-036 Same run -> hsync low exactly for x=10..12; de=1 only for x<8 and y<4; vsync low from (0,5) through (15,6).
REQ-037 pix_en high 1 clk in 4 -> x changes only on enabled edges; pulses exactly 1 clk wide; line period 64 clks.
REQ-038 H_POL=1, V_POL=0 -> hsync high during x=10..12, low elsewhere; vsync low during y=5..6.
REQ-039 rst for 3 clks at (5,2) with pix_en=1 -> outputs equal REQ-030 values (x=15,y=7); next enabled edge -> (0,0) with frame_start=1.
REQ-040 Default parameters -> frame_start period 712320 enabled clks; hsync active 56 pixels per line; vsync active 6 full lines.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared types and default timing for the VGA timing generator.
package vga_timing_pkg;

  // Phase within one axis of the raster. The order follows the scan order.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  // Default mode: 683x768 visible area, 896x795 total raster.
  localparam int DEF_H_ACTIVE = 683;
  localparam int DEF_H_FP     = 32;
  localparam int DEF_H_SYNC   = 56;
  localparam int DEF_H_BP     = 125;
  localparam int DEF_V_ACTIVE = 768;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 18;

  // Length of one full axis period (all four segments).
  function automatic int seg_total(input int a, input int f, input int s, input int b);
    return a + f + s + b;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumer.
// pix_en is a pure qualifier driven by the consumer: every rising clk edge
// with pix_en=1 advances the raster by one pixel; there is no backpressure,
// and all other signals are registered outputs describing the position on x/y.
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic                  pix_en;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic                  de;
  logic                  hsync;
  logic                  vsync;
  logic                  line_start;
  logic                  frame_start;
  // Current phase of each axis, exposed for observation.
  vga_timing_pkg::phase_t h_phase;
  vga_timing_pkg::phase_t v_phase;

  modport master (
    input  pix_en,
    output x, y, de, hsync, vsync, line_start, frame_start, h_phase, v_phase
  );

  modport slave (
    output pix_en,
    input  x, y, de, hsync, vsync, line_start, frame_start, h_phase, v_phase
  );
endinterface

// File: rtl/vga_phase_counter.sv
// One raster axis: position counter with explicit wrap plus the
// ACTIVE -> FRONT -> SYNC -> BACK phase FSM. Both step only when adv=1.
module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int SEG_ACTIVE = 8,
  parameter int SEG_FRONT  = 2,
  parameter int SEG_SYNC   = 3,
  parameter int SEG_BACK   = 3,
  parameter int W          = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] count,
  output logic         wrap,
  output phase_t       phase,
  output phase_t       phase_nxt
);

  localparam int TOTAL = seg_total(SEG_ACTIVE, SEG_FRONT, SEG_SYNC, SEG_BACK);

  // Last position of each segment; the FSM leaves a phase when adv hits it.
  localparam logic [W-1:0] END_ACTIVE = W'(SEG_ACTIVE - 1);
  localparam logic [W-1:0] END_FRONT  = W'(SEG_ACTIVE + SEG_FRONT - 1);
  localparam logic [W-1:0] END_SYNC   = W'(SEG_ACTIVE + SEG_FRONT + SEG_SYNC - 1);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

  // A zero-length segment would make two phase boundaries coincide.
  if (SEG_ACTIVE < 1 || SEG_FRONT < 1 || SEG_SYNC < 1 || SEG_BACK < 1) begin : g_bad_param
    $error("vga_phase_counter: every segment length must be at least 1");
  end

  logic [W-1:0] count_nxt;

  // Wrap flag from the registered count: the next advance returns to 0.
  assign wrap = (count == LAST);

  // Next position and next phase; both hold while adv=0.
  always_comb begin
    count_nxt = count;
    phase_nxt = phase;
    if (adv) begin
      count_nxt = wrap ? '0 : count + W'(1);
      case (phase)
        ACTIVE:  if (count == END_ACTIVE) phase_nxt = FRONT;
        FRONT:   if (count == END_FRONT)  phase_nxt = SYNC;
        SYNC:    if (count == END_SYNC)   phase_nxt = BACK;
        BACK:    if (wrap)                phase_nxt = ACTIVE;
        default: phase_nxt = BACK;
      endcase
    end
  end

  // Counter and FSM state; reset parks on the last position of BACK so the
  // first advance lands on position 0 in ACTIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= LAST;
      phase <= BACK;
    end else begin
      count <= count_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical phase counters plus
// registered de/sync/start outputs aligned with the x/y position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);

  logic [XW-1:0] h_count;
  logic [YW-1:0] v_count;
  logic          h_wrap;
  logic          v_wrap;
  logic          v_adv;
  phase_t        h_phase;
  phase_t        h_phase_nxt;
  phase_t        v_phase;
  phase_t        v_phase_nxt;

  // The vertical axis steps once per completed line.
  assign v_adv = bus.pix_en & h_wrap;

  vga_phase_counter #(
    .SEG_ACTIVE (H_ACTIVE),
    .SEG_FRONT  (H_FP),
    .SEG_SYNC   (H_SYNC),
    .SEG_BACK   (H_BP),
    .W          (XW)
  ) u_h (
    .clk       (clk),
    .rst       (rst),
    .adv       (bus.pix_en),
    .count     (h_count),
    .wrap      (h_wrap),
    .phase     (h_phase),
    .phase_nxt (h_phase_nxt)
  );

  vga_phase_counter #(
    .SEG_ACTIVE (V_ACTIVE),
    .SEG_FRONT  (V_FP),
    .SEG_SYNC   (V_SYNC),
    .SEG_BACK   (V_BP),
    .W          (YW)
  ) u_v (
    .clk       (clk),
    .rst       (rst),
    .adv       (v_adv),
    .count     (v_count),
    .wrap      (v_wrap),
    .phase     (v_phase),
    .phase_nxt (v_phase_nxt)
  );

  // Position and phases come straight from the counter registers.
  assign bus.x       = h_count;
  assign bus.y       = v_count;
  assign bus.h_phase = h_phase;
  assign bus.v_phase = v_phase;

  // Derived outputs are registered from the counters' next state so they
  // change on the same edge as x/y and always describe the shown position.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.de          <= 1'b0;
      bus.hsync       <= ~H_POL;
      bus.vsync       <= ~V_POL;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
      if (bus.pix_en) begin
        bus.de          <= (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
        bus.hsync       <= (h_phase_nxt == SYNC) ? H_POL : ~H_POL;
        bus.vsync       <= (v_phase_nxt == SYNC) ? V_POL : ~V_POL;
        bus.line_start  <= h_wrap;
        bus.frame_start <= h_wrap & v_wrap;
      end
    end
  end

endmodule
